// File: rtl/vram_painter.sv
// VRAM port-A write engine: paints square brush strokes from touch samples and
// performs full-screen clear sweeps, one registered write per clock.
module vram_painter #(
  parameter int X_RES          = 480,
  parameter int Y_RES          = 272,
  parameter int BITS_PER_PIXEL = 9,
  parameter int BRUSH_RADIUS   = 1,
  parameter logic [BITS_PER_PIXEL-1:0] CLEAR_COLOR = '0
) (
  input  logic                      cclk,
  input  logic                      rstb,
  input  logic                      touch_valid,
  input  logic [11:0]               touch_x,
  input  logic [11:0]               touch_y,
  input  logic [BITS_PER_PIXEL-1:0] pen_color,
  input  logic                      clear_req,
  output logic                      vram_wr_ena,
  output logic [16:0]               vram_wr_addr,
  output logic [BITS_PER_PIXEL-1:0] vram_wr_data,
  output logic                      busy,
  output logic                      clear_done,
  output logic [1:0]                dbg_state
);

  // Handshake: a write is one cycle of vram_wr_ena high; addr/data are only
  // meaningful in that cycle and simply hold otherwise. There is no backpressure.

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DONE} state_t;

  localparam logic [16:0]        LAST_ADDR = 17'(X_RES * Y_RES - 1);
  localparam logic [11:0]        X_MAX12   = 12'(X_RES);
  localparam logic [11:0]        Y_MAX12   = 12'(Y_RES);
  localparam logic signed [13:0] X_LIM     = 14'(X_RES);
  localparam logic signed [13:0] Y_LIM     = 14'(Y_RES);
  localparam logic signed [7:0]  R_POS     = 8'(BRUSH_RADIUS);
  localparam logic signed [7:0]  R_NEG     = -8'(BRUSH_RADIUS);

  state_t                    state;
  logic                      clear_q;
  logic                      clear_pending;
  logic [11:0]               cx;
  logic [11:0]               cy;
  logic [BITS_PER_PIXEL-1:0] color;
  logic signed [7:0]         dx;
  logic signed [7:0]         dy;
  logic [16:0]               clr_addr;

  logic                      clear_edge;
  logic                      touch_ok;
  logic signed [13:0]        px;
  logic signed [13:0]        py;
  logic                      pix_ok;
  logic [16:0]               pix_addr;

  assign dbg_state = state;

  // Candidate pixel in signed arithmetic so strokes near x=0/y=0 never wrap.
  always_comb begin
    clear_edge = clear_req & ~clear_q;
    touch_ok   = touch_valid && (touch_x < X_MAX12) && (touch_y < Y_MAX12);
    px         = $signed({2'b00, cx}) + 14'(dx);
    py         = $signed({2'b00, cy}) + 14'(dy);
    pix_ok     = (px >= 14'sd0) && (px < X_LIM) && (py >= 14'sd0) && (py < Y_LIM);
    pix_addr   = 17'(py) * 17'(X_RES) + 17'(px);
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      clear_q       <= 1'b0;
      clear_pending <= 1'b0;
      cx            <= '0;
      cy            <= '0;
      color         <= '0;
      dx            <= '0;
      dy            <= '0;
      clr_addr      <= '0;
      vram_wr_ena   <= 1'b0;
      vram_wr_addr  <= '0;
      vram_wr_data  <= '0;
      busy          <= 1'b0;
      clear_done    <= 1'b0;
    end else begin
      clear_q     <= clear_req;
      vram_wr_ena <= 1'b0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
      case (state)
        IDLE: begin
          // A clear (pending or arriving now) beats a simultaneous touch.
          if (clear_pending || clear_edge) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
            clr_addr      <= '0;
          end else if (touch_ok) begin
            cx    <= touch_x;
            cy    <= touch_y;
            color <= pen_color;
            dx    <= R_NEG;
            dy    <= R_NEG;
            state <= PAINT;
          end
        end
        PAINT: begin
          busy <= 1'b1;
          if (clear_edge) clear_pending <= 1'b1;
          if (pix_ok) begin
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= pix_addr;
            vram_wr_data <= color;
          end
          if (dx == R_POS) begin
            dx <= R_NEG;
            if (dy == R_POS) state <= IDLE;
            else             dy    <= dy + 8'sd1;
          end else begin
            dx <= dx + 8'sd1;
          end
        end
        CLEAR: begin
          busy         <= 1'b1;
          vram_wr_ena  <= 1'b1;
          vram_wr_addr <= clr_addr;
          vram_wr_data <= CLEAR_COLOR;
          clr_addr     <= clr_addr + 17'd1;
          if (clr_addr == LAST_ADDR) state <= DONE;
        end
        DONE: begin
          // Final sweep beat is on the outputs now; pulse completion next.
          clear_done <= 1'b1;
          if (clear_edge) clear_pending <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_painter.sv
// Bench for vram_painter with a reduced frame height so clear sweeps stay short.
module tb_vram_painter;

  localparam int XR   = 480;
  localparam int YR   = 16;
  localparam int NPIX = XR * YR;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        touch_valid = 1'b0;
  logic [11:0] touch_x = '0;
  logic [11:0] touch_y = '0;
  logic [8:0]  pen_color = '0;
  logic        clear_req = 1'b0;
  logic        vram_wr_ena;
  logic [16:0] vram_wr_addr;
  logic [8:0]  vram_wr_data;
  logic        busy;
  logic        clear_done;
  logic [1:0]  dbg_state;

  vram_painter #(.X_RES(XR), .Y_RES(YR)) dut (
    .cclk(cclk), .rstb(rstb), .touch_valid(touch_valid), .touch_x(touch_x),
    .touch_y(touch_y), .pen_color(pen_color), .clear_req(clear_req),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data), .busy(busy), .clear_done(clear_done),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 cclk = ~cclk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge cclk) begin
    if (rstb) begin
      logic [25:0] e;
      if (busy) busy_cnt++;
      if (clear_done) begin
        done_cnt++;
        check("done_after_last_write", exp_q.size(), 0);
      end
      if (vram_wr_ena) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                   vram_wr_addr, vram_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {15'd0, vram_wr_addr}, {15'd0, e[25:9]});
          check("wr_data", {23'd0, vram_wr_data}, {23'd0, e[8:0]});
          check("busy_with_write", {31'd0, busy}, 1);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic push(input int addr, input logic [8:0] data);
    exp_q.push_back({17'(addr), data});
  endtask

  task automatic push_sweep();
    for (int a = 0; a < NPIX; a++) push(a, 9'h000);
  endtask

  task automatic do_touch(input int x, input int y, input logic [8:0] c);
    touch_valid = 1'b1;
    touch_x = 12'(x);
    touch_y = 12'(y);
    pen_color = c;
    wait_cycles(1);
    touch_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    wait_cycles(1);
    clear_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < NPIX + 100) begin
      wait_cycles(1);
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic stroke(input string name, input int x, input int y, input logic [8:0] c,
                        input int exp_w, input int exp_b);
    int w0 = wr_cnt;
    int b0 = busy_cnt;
    do_touch(x, y, c);
    wait_cycles(15);
    check({name, "_writes"}, wr_cnt - w0, exp_w);
    check({name, "_busy_cycles"}, busy_cnt - b0, exp_b);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  int centre_a[9] = '{4419, 4420, 4421, 4899, 4900, 4901, 5379, 5380, 5381};
  int corner0_a[4] = '{0, 1, 480, 481};
  int corner1_a[4] = '{7198, 7199, 7678, 7679};
  int edge_a[6] = '{1920, 1921, 2400, 2401, 2880, 2881};

  initial begin
    int w0;
    int b0;
    int d0;
    int n;

    // reset
    rstb = 1'b0;
    wait_cycles(3);
    check("rst_wr_ena", {31'd0, vram_wr_ena}, 0);
    check("rst_wr_addr", {15'd0, vram_wr_addr}, 0);
    check("rst_wr_data", {23'd0, vram_wr_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_clear_done", {31'd0, clear_done}, 0);
    rstb = 1'b1;
    wait_cycles(5);
    check("no_write_after_reset", wr_cnt, 0);
    check("idle_after_reset", {30'd0, dbg_state}, 0);

    // strokes
    foreach (centre_a[i]) push(centre_a[i], 9'h1C0);
    stroke("centre", 100, 10, 9'h1C0, 9, 9);
    foreach (corner0_a[i]) push(corner0_a[i], 9'h03F);
    stroke("corner_00", 0, 0, 9'h03F, 4, 9);
    foreach (corner1_a[i]) push(corner1_a[i], 9'h155);
    stroke("corner_max", 479, 15, 9'h155, 4, 9);
    foreach (edge_a[i]) push(edge_a[i], 9'h007);
    stroke("left_edge", 0, 5, 9'h007, 6, 9);
    stroke("oor_x", 480, 10, 9'h1FF, 0, 0);
    stroke("oor_y", 5, 16, 9'h1FF, 0, 0);

    // touch during PAINT is ignored
    w0 = wr_cnt;
    foreach (centre_a[i]) push(centre_a[i], 9'h0A5);
    do_touch(100, 10, 9'h0A5);
    touch_valid = 1'b1;
    touch_x = 12'd200;
    wait_cycles(3);
    touch_valid = 1'b0;
    wait_cycles(15);
    check("paint_touch_ignored_writes", wr_cnt - w0, 9);

    // single clear pulse
    w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
    push_sweep();
    pulse_clear();
    wait_done(d0, "pulse_clear_done");
    wait_cycles(5);
    check("pulse_clear_writes", wr_cnt - w0, NPIX);
    check("pulse_clear_busy", busy_cnt - b0, NPIX);
    check("pulse_clear_single_done", done_cnt - d0, 1);

    // held clear level gives one sweep
    w0 = wr_cnt; d0 = done_cnt;
    push_sweep();
    clear_req = 1'b1;
    wait_done(d0, "held_clear_done");
    wait_cycles(200);
    clear_req = 1'b0;
    wait_cycles(5);
    check("held_clear_writes", wr_cnt - w0, NPIX);
    check("held_clear_single_done", done_cnt - d0, 1);

    // touch and clear edge together: sweep only
    w0 = wr_cnt; d0 = done_cnt;
    push_sweep();
    touch_valid = 1'b1; touch_x = 12'd100; touch_y = 12'd10; pen_color = 9'h1C0;
    clear_req = 1'b1;
    wait_cycles(1);
    touch_valid = 1'b0;
    clear_req = 1'b0;
    wait_done(d0, "contend_clear_done");
    wait_cycles(5);
    check("contend_writes", wr_cnt - w0, NPIX);

    // clear edge during stroke: stroke finishes, then sweep
    w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
    foreach (centre_a[i]) push(centre_a[i], 9'h0F0);
    push_sweep();
    do_touch(100, 10, 9'h0F0);
    wait_cycles(2);
    pulse_clear();
    wait_done(d0, "stroke_then_clear_done");
    wait_cycles(5);
    check("stroke_then_clear_writes", wr_cnt - w0, 9 + NPIX);
    check("stroke_then_clear_busy", busy_cnt - b0, 9 + NPIX);

    // reset at sweep address 5000
    d0 = done_cnt;
    push_sweep();
    pulse_clear();
    n = 0;
    do begin
      @(negedge cclk);
      n++;
    end while (!(vram_wr_ena && vram_wr_addr == 17'd5000) && n < NPIX);
    check("reached_addr_5000", {15'd0, vram_wr_addr}, 5000);
    #2 rstb = 1'b0;
    #1;
    check("async_rst_wr_ena", {31'd0, vram_wr_ena}, 0);
    check("async_rst_wr_addr", {15'd0, vram_wr_addr}, 0);
    check("async_rst_busy", {31'd0, busy}, 0);
    exp_q.delete();
    wait_cycles(3);
    rstb = 1'b1;
    w0 = wr_cnt;
    wait_cycles(20);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_writes", wr_cnt - w0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    push_sweep();
    pulse_clear();
    wait_done(d0, "restart_clear_done");
    wait_cycles(5);
    check("restart_clear_writes", wr_cnt - w0, NPIX);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
